// File: rtl/reg_file_param.sv
// Parametrised register file: two registered read ports, one byte-enabled write port,
// optional hardwired zero entry, optional write-to-read bypass and a post-reset clear engine.
module reg_file_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [ADDR_W-1:0]   Read_reg1,
  input  logic [ADDR_W-1:0]   Read_reg2,
  output logic [DATA_W-1:0]   Read_data1,
  output logic [DATA_W-1:0]   Read_data2,
  input  logic                Reg_write,
  input  logic [ADDR_W-1:0]   Write_reg,
  input  logic [DATA_W-1:0]   Write_data,
  input  logic [DATA_W/8-1:0] Write_be,
  output logic                Busy,
  output logic                Wr_drop
);

  localparam int unsigned NumBytes = DATA_W / 8;
  localparam int unsigned Depth    = 2 ** ADDR_W;

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                drop_q, drop_d;
  logic [DATA_W-1:0]   rd1_q, rd1_d;
  logic [DATA_W-1:0]   rd2_q, rd2_d;
  logic [DATA_W-1:0]   mem_q [Depth];

  logic                wr_ok;
  logic [DATA_W-1:0]   wr_merged;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   rd1_run, rd2_run;

  // Per-byte merge of the incoming write with the current entry contents.
  always_comb begin
    wr_merged = mem_q[Write_reg];
    for (int i = 0; i < int'(NumBytes); i++) begin
      if (Write_be[i]) wr_merged[8*i +: 8] = Write_data[8*i +: 8];
    end
  end

  assign wr_ok = Reg_write && !((ZERO_REG != 0) && (Write_reg == '0));

  always_comb begin
    if ((ZERO_REG != 0) && (Read_reg1 == '0)) begin
      rd1_run = '0;
    end else if ((BYPASS != 0) && wr_ok && (Read_reg1 == Write_reg)) begin
      rd1_run = wr_merged;
    end else begin
      rd1_run = mem_q[Read_reg1];
    end
    if ((ZERO_REG != 0) && (Read_reg2 == '0)) begin
      rd2_run = '0;
    end else if ((BYPASS != 0) && wr_ok && (Read_reg2 == Write_reg)) begin
      rd2_run = wr_merged;
    end else begin
      rd2_run = mem_q[Read_reg2];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    drop_d    = 1'b0;
    rd1_d     = '0;
    rd2_d     = '0;
    mem_we    = 1'b0;
    mem_waddr = Write_reg;
    mem_wdata = wr_merged;
    unique case (state_q)
      StClear: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        drop_d    = Reg_write;
        if (cnt_q == '1) begin
          state_d = StRun;
          busy_d  = 1'b0;
        end
      end
      StRun: begin
        mem_we = wr_ok;
        rd1_d  = rd1_run;
        rd2_d  = rd2_run;
        busy_d = 1'b0;
      end
      default: begin
        state_d = StClear;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= StClear;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      drop_q  <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
    end
  end

  // The array itself is never reset; the clear engine zeroes it after Rst falls.
  always_ff @(posedge Clk) begin
    if (!Rst && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign Read_data1 = rd1_q;
  assign Read_data2 = rd2_q;
  assign Busy       = busy_q;
  assign Wr_drop    = drop_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: a bypassing and a non-bypassing instance share stimulus and
// are compared each cycle against an array-based reference model plus directed constants.
module tb_reg_file_param;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int NB    = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, we;
  logic [AW-1:0] ra1, ra2, wa;
  logic [DW-1:0] wd;
  logic [NB-1:0] be;

  logic [DW-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic          busy_b, busy_n, drop_b, drop_n;

  reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) u_dut_byp (
    .Clk(clk), .Rst(rst), .Read_reg1(ra1), .Read_reg2(ra2), .Read_data1(rd1_b),
    .Read_data2(rd2_b), .Reg_write(we), .Write_reg(wa), .Write_data(wd), .Write_be(be),
    .Busy(busy_b), .Wr_drop(drop_b)
  );

  reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0)) u_dut_nob (
    .Clk(clk), .Rst(rst), .Read_reg1(ra1), .Read_reg2(ra2), .Read_data1(rd1_n),
    .Read_data2(rd2_n), .Reg_write(we), .Write_reg(wa), .Write_data(wd), .Write_be(be),
    .Busy(busy_n), .Wr_drop(drop_n)
  );

  logic [DW-1:0] mdl_mem [DEPTH];
  int            clear_left;
  int            n_vec;
  int            n_err;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply the currently driven inputs for one edge and compare all outputs to the model.
  task automatic step();
    logic [DW-1:0] merged, e1b, e2b, e1n, e2n;
    logic          ebusy, edrop;
    bit            wr_ok;
    merged = mdl_mem[wa];
    for (int i = 0; i < NB; i++) if (be[i]) merged[8*i +: 8] = wd[8*i +: 8];
    wr_ok = we && (wa != 0);
    e1b = '0; e2b = '0; e1n = '0; e2n = '0;
    if (rst) begin
      ebusy = 1'b1;
      edrop = 1'b0;
    end else if (clear_left > 0) begin
      edrop = we;
      ebusy = (clear_left > 1);
    end else begin
      edrop = 1'b0;
      ebusy = 1'b0;
      if (ra1 != 0) begin
        e1n = mdl_mem[ra1];
        e1b = (wr_ok && ra1 == wa) ? merged : mdl_mem[ra1];
      end
      if (ra2 != 0) begin
        e2n = mdl_mem[ra2];
        e2b = (wr_ok && ra2 == wa) ? merged : mdl_mem[ra2];
      end
    end
    @(posedge clk);
    if (rst) begin
      clear_left = DEPTH;
    end else if (clear_left > 0) begin
      mdl_mem[DEPTH - clear_left] = '0;
      clear_left--;
    end else if (wr_ok) begin
      mdl_mem[wa] = merged;
    end
    #1;
    check("rd1_byp", rd1_b, e1b);
    check("rd2_byp", rd2_b, e2b);
    check("rd1_nob", rd1_n, e1n);
    check("rd2_nob", rd2_n, e2n);
    check("busy_byp", DW'(busy_b), DW'(ebusy));
    check("busy_nob", DW'(busy_n), DW'(ebusy));
    check("drop_byp", DW'(drop_b), DW'(edrop));
    check("drop_nob", DW'(drop_n), DW'(edrop));
  endtask

  task automatic set_in(input logic r, input logic w, input logic [AW-1:0] a_w,
                        input logic [DW-1:0] d, input logic [NB-1:0] b,
                        input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    rst = r; we = w; wa = a_w; wd = d; be = b; ra1 = a1; ra2 = a2;
  endtask

  initial begin
    int busy_len, drops, reqs;
    n_vec = 0;
    n_err = 0;
    clear_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;

    // Reset for two cycles, then time the clear.
    set_in(1, 0, 0, 0, 0, 0, 0);
    step();
    step();
    set_in(0, 0, 0, 0, 0, 0, 0);
    busy_len = 0;
    while (busy_b === 1'b1 && busy_len < 100) begin
      step();
      busy_len++;
    end
    check("busy_len", DW'(busy_len), DW'(32));

    for (int a = 0; a < DEPTH; a++) begin
      set_in(0, 0, 0, 0, 0, AW'(a), AW'(DEPTH - 1 - a));
      step();
      check("post_clear", rd1_b, 32'h0);
    end

    // Full-word write then read-back.
    set_in(0, 1, 12, 32'h0000c0a0, 4'hF, 0, 0);
    step();
    set_in(0, 0, 0, 0, 0, 12, 12);
    step();
    check("wr_rd12", rd1_b, 32'h0000c0a0);

    // Byte-enable merge.
    set_in(0, 1, 2, 32'h11223344, 4'hF, 0, 0);
    step();
    set_in(0, 1, 2, 32'hAABBCCDD, 4'b0101, 0, 0);
    step();
    set_in(0, 0, 0, 0, 0, 2, 2);
    step();
    check("be_merge", rd1_b, 32'h11BB33DD);

    // Same-edge bypass on reg 16.
    set_in(0, 1, 16, 32'h00a5d604, 4'hF, 0, 16);
    step();
    check("bypass_new", rd2_b, 32'h00a5d604);
    check("nobypass_old", rd2_n, 32'h0);
    set_in(0, 0, 0, 0, 0, 0, 16);
    step();
    check("nobypass_next", rd2_n, 32'h00a5d604);

    // Zero register.
    set_in(0, 1, 0, 32'hFFFFFFFF, 4'hF, 0, 0);
    step();
    check("zero_rd1", rd1_b, 32'h0);
    check("zero_rd2", rd2_n, 32'h0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    step();
    check("zero_later", rd1_n, 32'h0);

    // Reset mid-clear with writes requested throughout.
    set_in(1, 0, 0, 0, 0, 0, 0);
    step();
    drops = 0;
    reqs = 0;
    for (int c = 0; c < 10; c++) begin
      set_in(0, 1'(c % 2), 5, 32'h12345678, 4'hF, 5, 5);
      reqs += c % 2;
      step();
      if (drop_b === 1'b1) drops++;
    end
    set_in(1, 0, 0, 0, 0, 0, 0);
    step();
    set_in(0, 1, 5, 32'h12345678, 4'hF, 5, 5);
    busy_len = 0;
    while (busy_b === 1'b1 && busy_len < 100) begin
      step();
      busy_len++;
      reqs++;
      if (drop_b === 1'b1) drops++;
    end
    check("restart_busy_len", DW'(busy_len), DW'(32));
    check("drop_count", DW'(drops), DW'(reqs));
    set_in(0, 0, 0, 0, 0, 5, 5);
    step();
    check("reg5_zero", rd1_b, 32'h0);

    // Random traffic, with occasional resets.
    for (int n = 0; n < 600; n++) begin
      logic [AW-1:0] a_w;
      a_w = AW'($urandom_range(0, DEPTH - 1));
      set_in(1'($urandom_range(0, 249) == 0), 1'($urandom_range(0, 1)), a_w, DW'($urandom),
             NB'($urandom_range(0, 15)),
             ($urandom_range(0, 1) != 0) ? a_w : AW'($urandom_range(0, DEPTH - 1)),
             ($urandom_range(0, 1) != 0) ? a_w : AW'($urandom_range(0, DEPTH - 1)));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
